// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants, segment indices and shared types for seg7_display_ctrl
package seg7_pkg;

    localparam int SEG_TOP = 0;
    localparam int SEG_MID = 6;

    typedef logic [3:0]             nibble_t;
    typedef logic [SEG_MID:SEG_TOP] seg_t;

    // Active-low patterns: bit 0 top, bits 1..5 clockwise, bit 6 middle
    localparam seg_t GLYPH_0     = 7'h40;
    localparam seg_t GLYPH_1     = 7'h79;
    localparam seg_t GLYPH_2     = 7'h24;
    localparam seg_t GLYPH_3     = 7'h30;
    localparam seg_t GLYPH_4     = 7'h19;
    localparam seg_t GLYPH_5     = 7'h12;
    localparam seg_t GLYPH_6     = 7'h02;
    localparam seg_t GLYPH_7     = 7'h78;
    localparam seg_t GLYPH_8     = 7'h00;
    localparam seg_t GLYPH_9     = 7'h18;
    localparam seg_t GLYPH_A     = 7'h08;
    localparam seg_t GLYPH_B     = 7'h03;
    localparam seg_t GLYPH_C     = 7'h46;
    localparam seg_t GLYPH_D     = 7'h21;
    localparam seg_t GLYPH_E     = 7'h06;
    localparam seg_t GLYPH_F     = 7'h0E;
    localparam seg_t GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/seg7_glyph_lut.sv
// rtl/seg7_glyph_lut.sv - combinational hex nibble to active-low seven-segment pattern
module seg7_glyph_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0:    seg = GLYPH_0;
                4'h1:    seg = GLYPH_1;
                4'h2:    seg = GLYPH_2;
                4'h3:    seg = GLYPH_3;
                4'h4:    seg = GLYPH_4;
                4'h5:    seg = GLYPH_5;
                4'h6:    seg = GLYPH_6;
                4'h7:    seg = GLYPH_7;
                4'h8:    seg = GLYPH_8;
                4'h9:    seg = GLYPH_9;
                4'hA:    seg = GLYPH_A;
                4'hB:    seg = GLYPH_B;
                4'hC:    seg = GLYPH_C;
                4'hD:    seg = GLYPH_D;
                4'hE:    seg = GLYPH_E;
                default: seg = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit seven-segment controller; define SEG7_SCAN_EN for the scan bus
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    input  logic                    i_blank_lz,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [7*NUM_DIGITS-1:0] o_seg,
    output logic [NUM_DIGITS-1:0]   o_dp,
    output logic [6:0]              o_scan_seg,
    output logic                    o_scan_dp,
    output logic [NUM_DIGITS-1:0]   o_scan_sel
);

    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || SCAN_DIV < 1 || BLINK_HALF < 1) begin : g_bad_params
    end

    ctrl_state_t state_q, state_d;
    logic        xfer, commit, commit_ok;

    logic [4*NUM_DIGITS-1:0] pend_data, disp_data;
    logic [NUM_DIGITS-1:0]   pend_dp, pend_blink, disp_dp, disp_blink;
    logic                    pend_blank_lz, disp_blank_lz, disp_valid;

    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;

    logic [NUM_DIGITS-1:0]   lz_blank, dig_blank, dp_next;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic                    nz_seen;

    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        xfer    = 1'b0;
        commit  = 1'b0;
        o_ready = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    xfer    = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (commit_ok) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pend_data     <= '0;
            pend_dp       <= '0;
            pend_blink    <= '0;
            pend_blank_lz <= 1'b0;
            disp_data     <= '0;
            disp_dp       <= '0;
            disp_blink    <= '0;
            disp_blank_lz <= 1'b0;
            disp_valid    <= 1'b0;
        end else if (xfer) begin
            pend_data     <= i_data;
            pend_dp       <= i_dp;
            pend_blink    <= i_blink;
            pend_blank_lz <= i_blank_lz;
        end else if (commit) begin
            disp_data     <= pend_data;
            disp_dp       <= pend_dp;
            disp_blink    <= pend_blink;
            disp_blank_lz <= pend_blank_lz;
            disp_valid    <= 1'b1;
            pend_data     <= '0;
            pend_dp       <= '0;
            pend_blink    <= '0;
            pend_blank_lz <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Walk down from the top digit; blanking stops at the first non-zero nibble
    always_comb begin
        lz_blank = '0;
        nz_seen  = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nz_seen     = nz_seen | (disp_data[4*d +: 4] != 4'h0);
            lz_blank[d] = disp_blank_lz && !nz_seen && (d != 0);
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic blink_off;
        assign blink_off    = disp_blink[d] && blink_phase;
        assign dig_blank[d] = !disp_valid || lz_blank[d] || blink_off;
        // Leading-zero blanking leaves the decimal point alone
        assign dp_next[d]   = !(disp_valid && disp_dp[d] && !blink_off);

        seg7_glyph_lut u_lut (
            .nibble (disp_data[4*d +: 4]),
            .blank  (dig_blank[d]),
            .seg    (seg_next[7*d +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_seg <= '1;
            o_dp  <= '1;
        end else begin
            o_seg <= seg_next;
            o_dp  <= dp_next;
        end
    end

`ifdef SEG7_SCAN_EN
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      scan_idx;
    nibble_t               scan_nib;
    logic                  scan_blank;
    logic [6:0]            scan_glyph;
    logic [NUM_DIGITS-1:0] scan_onehot;

    // New data lands only at the frame boundary so a frame never mixes old and new digits
    assign commit_ok  = (scan_cnt == SCAN_LAST) && (scan_idx == IDX_LAST);
    assign scan_nib   = disp_data[4*scan_idx +: 4];
    assign scan_blank = dig_blank[scan_idx];

    always_comb begin
        scan_onehot           = '0;
        scan_onehot[scan_idx] = 1'b1;
    end

    seg7_glyph_lut u_scan_lut (
        .nibble (scan_nib),
        .blank  (scan_blank),
        .seg    (scan_glyph)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            scan_cnt   <= '0;
            scan_idx   <= '0;
            o_scan_seg <= GLYPH_BLANK;
            o_scan_dp  <= 1'b1;
            o_scan_sel <= '1;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            o_scan_seg <= scan_glyph;
            o_scan_dp  <= dp_next[scan_idx];
            o_scan_sel <= ~scan_onehot;
        end
    end
`else
    assign commit_ok  = 1'b1;
    assign o_scan_seg = GLYPH_BLANK;
    assign o_scan_dp  = 1'b1;
    assign o_scan_sel = '1;
`endif

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - directed vector bench for seg7_display_ctrl (8 digits, SCAN_DIV 3, BLINK_HALF 4)
module tb_seg7_display_ctrl;

    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [31:0]   i_data;
    logic [7:0]    i_dp;
    logic [7:0]    i_blink;
    logic          i_blank_lz;
    logic          i_valid;
    logic          o_ready;
    logic [55:0]   o_seg;
    logic [7:0]    o_dp;
    logic [6:0]    o_scan_seg;
    logic          o_scan_dp;
    logic [7:0]    o_scan_sel;

    int n_vec  = 0;
    int n_fail = 0;
    int ecount = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        blz;
        logic [55:0] seg;
        logic [7:0]  odp;
    } vec_t;

    vec_t tbl [8];

    seg7_display_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (3),
        .BLINK_HALF (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_data     (i_data),
        .i_dp       (i_dp),
        .i_blink    (i_blink),
        .i_blank_lz (i_blank_lz),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_seg      (o_seg),
        .o_dp       (o_dp),
        .o_scan_seg (o_scan_seg),
        .o_scan_dp  (o_scan_dp),
        .o_scan_sel (o_scan_sel)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge, used to predict blink phase and scan position
    always @(posedge clk) begin
        if (!n_rst) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: wait expired, got no ready, want ready", name);
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] dp,
                        input logic [7:0] bl, input logic blz);
        int t;
        i_data = d; i_dp = dp; i_blink = bl; i_blank_lz = blz; i_valid = 1'b1;
        t = 0;
        while (o_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) timeout("xfer_wait");
        @(negedge clk);
        i_valid = 1'b0;
        chk("ready_drop", {63'd0, o_ready}, 64'd0);
        t = 0;
        while (o_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) timeout("commit_wait");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sel_exp;
        int         t;

        tbl[0] = '{32'h0000_12AF, 8'h00, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E}, 8'hFF};
        tbl[1] = '{32'h0000_12AF, 8'h00, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E}, 8'hFF};
        tbl[2] = '{32'h0000_0000, 8'h00, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFF};
        tbl[3] = '{32'h89AB_CDEF, 8'hA5, 1'b0, {7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'h5A};
        tbl[4] = '{32'h0012_3456, 8'hC0, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 8'h3F};
        tbl[5] = '{32'h0100_0000, 8'h00, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFF};
        tbl[6] = '{32'h0000_0000, 8'h00, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFF};
        tbl[7] = '{32'h7000_0000, 8'h01, 1'b1, {7'h78, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFE};

        n_rst = 1'b0; i_data = '0; i_dp = '0; i_blink = '0; i_blank_lz = 1'b0; i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", {8'd0, o_seg}, {8'd0, {56{1'b1}}});
        chk("rst_dp", {56'd0, o_dp}, 64'hFF);
        chk("rst_scan_seg", {57'd0, o_scan_seg}, 64'h7F);
        chk("rst_scan_dp", {63'd0, o_scan_dp}, 64'd1);
        chk("rst_scan_sel", {56'd0, o_scan_sel}, 64'hFF);
        chk("rst_ready", {63'd0, o_ready}, 64'd0);

        n_rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, o_ready}, 64'd1);
        chk("blank_before_commit", {8'd0, o_seg}, {8'd0, {56{1'b1}}});

`ifdef SEG7_SCAN_EN
        chk("scan_sel_first", {56'd0, o_scan_sel}, 64'hFE);
        i_data = 32'h0000_12AF; i_dp = 8'h02; i_blink = '0; i_blank_lz = 1'b0; i_valid = 1'b1;
        for (int e = 2; e <= 48; e++) begin
            int         idx;
            logic [6:0] es;
            logic       edp;
            @(negedge clk);
            idx     = ((e - 1) / 3) % 8;
            es      = (e <= 24) ? 7'h7F : tbl[0].seg[7*idx +: 7];
            edp     = (e <= 24) ? 1'b1 : (idx != 1);
            sel_exp = ~(8'h01 << idx);
            chk($sformatf("scan_sel_e%0d", e), {56'd0, o_scan_sel}, {56'd0, sel_exp});
            chk($sformatf("scan_seg_e%0d", e), {57'd0, o_scan_seg}, {57'd0, es});
            chk($sformatf("scan_dp_e%0d", e), {63'd0, o_scan_dp}, {63'd0, edp});
            if (e == 2 || e == 23 || e == 24)
                chk($sformatf("scan_ready_e%0d", e), {63'd0, o_ready}, {63'd0, (e == 24)});
            if (e == 2)  i_data = 32'hFFFF_FFFF;
            if (e == 10) i_valid = 1'b0;
        end
`else
        i_data = 32'h0000_12AF; i_dp = 8'h02; i_blink = '0; i_blank_lz = 1'b0; i_valid = 1'b1;
        @(negedge clk);
        chk("k_ready", {63'd0, o_ready}, 64'd0);
        chk("k_seg_old", {8'd0, o_seg}, {8'd0, {56{1'b1}}});
        i_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("k1_ready", {63'd0, o_ready}, 64'd1);
        chk("k1_seg_old", {8'd0, o_seg}, {8'd0, {56{1'b1}}});
        i_valid = 1'b0;
        @(negedge clk);
        chk("k2_seg", {8'd0, o_seg}, {8'd0, tbl[0].seg});
        chk("k2_dp", {56'd0, o_dp}, 64'hFD);
        chk("noscan_seg", {57'd0, o_scan_seg}, 64'h7F);
        chk("noscan_dp", {63'd0, o_scan_dp}, 64'd1);
        chk("noscan_sel", {56'd0, o_scan_sel}, 64'hFF);
`endif

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].data, tbl[i].dp, 8'h00, tbl[i].blz);
            chk($sformatf("vec%0d_seg", i), {8'd0, o_seg}, {8'd0, tbl[i].seg});
            chk($sformatf("vec%0d_dp", i), {56'd0, o_dp}, {56'd0, tbl[i].odp});
        end

        send(32'h0000_12AF, 8'h01, 8'h01, 1'b0);
        for (int j = 0; j < 16; j++) begin
            logic       ph;
            logic [6:0] d0;
            @(negedge clk);
            ph = (((ecount - 1) / 4) % 2) == 1;
            d0 = ph ? 7'h7F : 7'h0E;
            chk($sformatf("blink_d0_%0d", j), {57'd0, o_seg[6:0]}, {57'd0, d0});
            chk($sformatf("blink_d1_%0d", j), {57'd0, o_seg[13:7]}, 64'h08);
            chk($sformatf("blink_dp0_%0d", j), {63'd0, o_dp[0]}, {63'd0, ph});
        end

        i_data = 32'h0000_5555; i_dp = 8'hFF; i_blink = '0; i_blank_lz = 1'b0; i_valid = 1'b1;
        t = 0;
        while (o_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) timeout("rst_xfer_wait");
        @(negedge clk);
        i_valid = 1'b0;
        chk("pend_ready", {63'd0, o_ready}, 64'd0);
        n_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_seg", {8'd0, o_seg}, {8'd0, {56{1'b1}}});
        chk("mid_rst_dp", {56'd0, o_dp}, 64'hFF);
        chk("mid_rst_scan_seg", {57'd0, o_scan_seg}, 64'h7F);
        chk("mid_rst_scan_dp", {63'd0, o_scan_dp}, 64'd1);
        chk("mid_rst_scan_sel", {56'd0, o_scan_sel}, 64'hFF);
        chk("mid_rst_ready", {63'd0, o_ready}, 64'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, o_ready}, 64'd1);
`ifdef SEG7_SCAN_EN
        chk("post_rst_scan_sel", {56'd0, o_scan_sel}, 64'hFE);
`endif
        repeat (30) @(negedge clk);
        chk("pend_discard_seg", {8'd0, o_seg}, {8'd0, {56{1'b1}}});
        chk("pend_discard_dp", {56'd0, o_dp}, 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
